adpcm_fetch: RTL and testbench
==============================

ADPCM_FETCH -- requirements
Module: adpcm_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, same clock as the SDRAM controller.
REQ-002 SHALL have ports: nRESET  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, latches start_addr/end_addr and begins playback.
REQ-004 SHALL have ports: stop  in  1  one-cycle pulse, aborts playback.
REQ-005 SHALL have ports: start_addr  in  24  first 32-bit word address [25:2]; end_addr  in  24  last word address, inclusive.
REQ-006 SHALL have ports: nib_rd  in  1  consumer takes nib_out this cycle.
REQ-007 SHALL have ports: nib_out  out  4  current nibble; nib_valid  out  1  nib_out valid.
REQ-008 SHALL have ports: busy  out  1  playback active; end_flag  out  1  one-cycle pulse at end of sample.
REQ-009 SHALL have ports: mem_req  out  1  toggle request; mem_ack  in  1  toggle ack; mem_addr  out  26  byte address, [1:0]=0; mem_q  in  32  returned word.

Function
REQ-010 Handshake: a request is issued by inverting mem_req with mem_addr stable; it completes on the first cycle mem_ack==mem_req; at most one outstanding request.
REQ-011 mem_q SHALL be captured on the completion cycle; mem_addr SHALL NOT change while a request is outstanding.
REQ-012 States IDLE, RUN, DRAIN: start->RUN; RUN->DRAIN when word end_addr has been requested; DRAIN->IDLE when the buffer is empty and no request is outstanding.
REQ-013 In RUN, a request SHALL be issued in the cycle after a buffer slot is free and no request is outstanding; the fetch address increments by 1 word after each issue.
REQ-014 Nibble order within a word SHALL be [7:4],[3:0],[15:12],[11:8],[23:20],[19:16],[31:28],[27:24]; a 3-bit nibble index wraps 7->0 and pops the word.
REQ-015 nib_valid SHALL be high whenever the buffer holds a word; nib_rd with nib_valid low SHALL be ignored.
REQ-016 First nib_valid SHALL appear one cycle after the first completion; latency from start to first request is 1 cycle.
REQ-017 end_flag SHALL pulse in the cycle after the last nibble of word end_addr is consumed; busy falls in the same cycle.
REQ-018 start_addr > end_addr: no request issued, busy stays low, end_flag pulses one cycle after start.
REQ-019 Word-address arithmetic is 24-bit modulo; end_addr=24'hFFFFFF SHALL terminate without wrapping.
REQ-020 stop SHALL flush the buffer, clear nib_valid next cycle, go to IDLE without end_flag; an outstanding request completes and its data is discarded.
REQ-021 start during RUN/DRAIN SHALL restart at the new addresses; any in-flight word is discarded, and the new first request waits for that completion.
REQ-022 start and stop in the same cycle: stop wins.

Reset
REQ-023 With nRESET low at a clk edge: state IDLE, mem_req=0, internal ack copy=0, buffer empty, nib_out=0, nib_valid=0, busy=0, end_flag=0, mem_addr=0.
REQ-024 Deasserting reset mid-request SHALL NOT be supported; reset is asserted together with the SDRAM controller reset.

Configuration
REQ-025 Macro ADPCM_FETCH_PREFETCH_EN defined: 2-entry word buffer; the next word is fetched while the current one is consumed.
REQ-026 Macro not defined: 1-entry buffer; a request is issued only after the current word is popped; nibble order and handshake are unchanged.

Structure
REQ-027 Package adpcm_pkg SHALL hold the state enum, the word-address width (24) and the nibble-index width (3).
REQ-028 Sub-module adpcm_word_fifo (depth 1 or 2 per macro; push, pop, flush, empty, full) SHALL hold the buffer.

Verification
REQ-029 start 0x000010..0x000011, ack 3 cycles after each req -> mem_addr 0x40 then 0x44; 16 nibbles in REQ-014 order; end_flag once; busy low after.
REQ-030 start_addr=5, end_addr=4 -> no mem_req toggle; end_flag pulses at start+1.
REQ-031 stop while a request is outstanding, ack 10 cycles later -> nib_valid low, no end_flag, captured word not presented, no further requests.
REQ-032 start 0x100..0x100 issued during a restart with an in-flight ack -> first nibble comes from word 0x100, not the stale word.
REQ-033 nib_rd held high every cycle with PREFETCH_EN and ack latency 2 -> no nib_valid gaps after the first word; without the macro -> gaps present, data identical.
REQ-034 nRESET low mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/adpcm_pkg.sv
// Shared types and widths for the ADPCM sample fetcher.
package adpcm_pkg;

    localparam int unsigned WordAddrW = 24;
    localparam int unsigned NibIdxW   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Nibble k lives in byte k/2; even k takes the high half of that byte.
    function automatic logic [3:0] nib_sel(input logic [31:0] word,
                                           input logic [NibIdxW-1:0] idx);
        logic [4:0] lsb;
        lsb = {idx[2:1], ~idx[0], 2'b00};
        return word[lsb +: 4];
    endfunction

endpackage

// File: rtl/adpcm_word_fifo.sv
// Small shift-style word buffer holding fetched sample words (depth 1 or 2).
module adpcm_word_fifo #(
    parameter int unsigned Depth = 1
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        empty,
    output logic        full
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [31:0]     mem_q [Depth];
    logic [31:0]     mem_d [Depth];
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (pop && (cnt_q != '0)) begin
                for (int i = 0; i < int'(Depth) - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                cnt_d = cnt_q - CntW'(1);
            end
            // Push lands behind whatever survives this cycle's pop.
            if (push && (cnt_d != CntW'(Depth))) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    if (cnt_d == CntW'(i)) begin
                        mem_d[i] = wdata;
                    end
                end
                cnt_d = cnt_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[0];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/adpcm_fetch.sv
// ADPCM sample fetcher: pulls words over a toggle handshake and streams nibbles.
// Define ADPCM_FETCH_PREFETCH_EN for a 2-word buffer that fetches ahead.
module adpcm_fetch
    import adpcm_pkg::*;
(
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WordAddrW-1:0] start_addr,
    input  logic [WordAddrW-1:0] end_addr,
    input  logic                 nib_rd,
    output logic [3:0]           nib_out,
    output logic                 nib_valid,
    output logic                 busy,
    output logic                 end_flag,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [25:0]          mem_addr,
    input  logic [31:0]          mem_q
);

`ifdef ADPCM_FETCH_PREFETCH_EN
    localparam int unsigned BufDepth = 2;
`else
    localparam int unsigned BufDepth = 1;
`endif

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 ack_q, ack_d;
    logic                 discard_q, discard_d;
    logic                 end_flag_q, end_flag_d;
    logic [WordAddrW-1:0] mem_addr_q, mem_addr_d;
    logic [WordAddrW-1:0] fetch_addr_q, fetch_addr_d;
    logic [WordAddrW-1:0] end_addr_q, end_addr_d;
    logic [NibIdxW-1:0]   nib_idx_q, nib_idx_d;

    logic        outstanding, complete, nib_fire, pop, push, flush, one_left;
    logic        issue;
    logic [WordAddrW-1:0] issue_addr;
    logic [31:0] buf_word;
    logic        buf_empty, buf_full;

    assign outstanding = (mem_req_q != ack_q);
    assign complete    = outstanding && (mem_ack == mem_req_q);
    assign nib_valid   = !buf_empty;
    assign nib_fire    = nib_rd && nib_valid;
    assign pop         = nib_fire && (nib_idx_q == NibIdxW'(7));
    assign flush       = stop || start;
    assign push        = complete && !discard_q && !flush;
`ifdef ADPCM_FETCH_PREFETCH_EN
    assign one_left    = !buf_empty && !buf_full;
`else
    assign one_left    = buf_full;
`endif

    adpcm_word_fifo #(
        .Depth (BufDepth)
    ) u_word_fifo (
        .clk    (clk),
        .nRESET (nRESET),
        .push   (push),
        .wdata  (mem_q),
        .pop    (pop),
        .flush  (flush),
        .rdata  (buf_word),
        .empty  (buf_empty),
        .full   (buf_full)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        ack_d        = ack_q;
        discard_d    = discard_q;
        end_flag_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        fetch_addr_d = fetch_addr_q;
        end_addr_d   = end_addr_q;
        nib_idx_d    = nib_idx_q;
        issue        = 1'b0;
        issue_addr   = fetch_addr_q;

        if (complete) begin
            ack_d     = mem_req_q;
            discard_d = 1'b0;
        end
        // A request still in flight when we abort or restart returns stale data.
        if (flush && outstanding && !complete) begin
            discard_d = 1'b1;
        end
        if (nib_fire) begin
            nib_idx_d = nib_idx_q + NibIdxW'(1);
        end

        if (stop) begin
            state_d   = StIdle;
            nib_idx_d = '0;
        end else if (start) begin
            nib_idx_d  = '0;
            end_addr_d = end_addr;
            if (start_addr > end_addr) begin
                state_d    = StIdle;
                end_flag_d = 1'b1;
            end else begin
                state_d      = (start_addr == end_addr) ? StDrain : StRun;
                fetch_addr_d = start_addr;
                if (!outstanding) begin
                    issue        = 1'b1;
                    issue_addr   = start_addr;
                    fetch_addr_d = start_addr + WordAddrW'(1);
                end else begin
                    state_d = StRun;
                end
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!outstanding && !buf_full) begin
                        issue        = 1'b1;
                        fetch_addr_d = fetch_addr_q + WordAddrW'(1);
                        if (fetch_addr_q == end_addr_q) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!outstanding && (buf_empty || (pop && one_left))) begin
                        state_d    = StIdle;
                        end_flag_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (issue) begin
            mem_req_d  = ~mem_req_q;
            mem_addr_d = issue_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            ack_q        <= 1'b0;
            discard_q    <= 1'b0;
            end_flag_q   <= 1'b0;
            mem_addr_q   <= '0;
            fetch_addr_q <= '0;
            end_addr_q   <= '0;
            nib_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            ack_q        <= ack_d;
            discard_q    <= discard_d;
            end_flag_q   <= end_flag_d;
            mem_addr_q   <= mem_addr_d;
            fetch_addr_q <= fetch_addr_d;
            end_addr_q   <= end_addr_d;
            nib_idx_q    <= nib_idx_d;
        end
    end

    assign nib_out  = nib_valid ? nib_sel(buf_word, nib_idx_q) : 4'h0;
    assign busy     = (state_q != StIdle);
    assign end_flag = end_flag_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = {mem_addr_q, 2'b00};

endmodule

// File: tb/tb_adpcm_fetch.sv
// Directed bench for adpcm_fetch with a toggle-handshake memory model and nibble scoreboard.
module tb_adpcm_fetch;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] start_addr = '0;
    logic [23:0] end_addr = '0;
    logic        nib_rd = 1'b0;
    logic [3:0]  nib_out;
    logic        nib_valid, busy, end_flag, mem_req;
    logic        mem_ack = 1'b0;
    logic [25:0] mem_addr;
    logic [31:0] mem_q = '0;

    int total = 0;
    int bad = 0;
    int ack_lat = 3;
    bit rd_en = 0;
    bit rd_rand = 0;
    int end_cnt = 0;
    int gaps = 0;
    bit gap_mode = 0;
    bit saw_valid = 0;
    logic [3:0]  exp_q[$];
    logic [25:0] req_q[$];

    bit          r_pend = 0;
    int          r_cnt = 0;
    logic [25:0] r_addr = '0;
    logic        r_req = 1'b0;

    always #5 clk = ~clk;

    adpcm_fetch dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .nib_rd     (nib_rd),
        .nib_out    (nib_out),
        .nib_valid  (nib_valid),
        .busy       (busy),
        .end_flag   (end_flag),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [23:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3, a[23:16] ^ 8'h96, a[7:0] + 8'h1F};
    endfunction

    task automatic push_word(input logic [23:0] a);
        int sh[8] = '{4, 0, 12, 8, 20, 16, 28, 24};
        logic [31:0] w;
        w = word_of(a);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[sh[i] +: 4]);
    endtask

    task automatic pulse(input logic [23:0] sa, input logic [23:0] ea,
                         input bit do_start, input bit do_stop);
        @(posedge clk); #1;
        start_addr = sa;
        end_addr   = ea;
        start      = do_start;
        stop       = do_stop;
        exp_q.delete();
        if (do_start && !do_stop)
            for (longint a = longint'(sa); a <= longint'(ea); a++) push_word(24'(a));
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_nib_valid"}, 32'(nib_valid), 32'd0);
        chk({tag, "_nib_out"}, 32'(nib_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_flag"}, 32'(end_flag), 32'd0);
    endtask

    // Memory model: answers each toggle after ack_lat cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!nRESET) begin
                r_pend  = 0;
                mem_ack = 1'b0;
            end else if (r_pend) begin
                chk("addr_stable", 32'(mem_addr), 32'(r_addr));
                if (r_cnt == 0) begin
                    mem_q   = word_of(r_addr[25:2]);
                    mem_ack = r_req;
                    r_pend  = 0;
                end else begin
                    r_cnt--;
                end
            end else if (mem_req !== mem_ack) begin
                r_pend = 1;
                r_addr = mem_addr;
                r_req  = mem_req;
                r_cnt  = ack_lat - 1;
                req_q.push_back(mem_addr);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            nib_rd = rd_rand ? 1'($urandom_range(0, 1)) : rd_en;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (nRESET) begin
                if (end_flag) end_cnt++;
                if (nib_valid && nib_rd) begin
                    if (exp_q.size() == 0) chk("nib_extra", 32'(exp_q.size()), 32'd1);
                    else chk("nib", 32'(nib_out), 32'(exp_q.pop_front()));
                end
                if (gap_mode) begin
                    if (nib_valid) saw_valid = 1;
                    else if (busy && saw_valid && exp_q.size() != 0) gaps++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        bit found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs("rst");
        @(posedge clk); #1;
        nRESET = 1'b1;

        // Two-word playback, first-request and first-valid timing.
        ack_lat = 3; rd_en = 1; end_cnt = 0; req_q.delete();
        pulse(24'h10, 24'h11, 1, 0);
        @(negedge clk);
        chk("t1_first_req", 32'(mem_req), 32'd1);
        chk("t1_first_addr", 32'(mem_addr), 32'h40);
        chk("t1_busy", 32'(busy), 32'd1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_ack === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t1_ack_seen", 32'(got), 32'd1);
        chk("t1_valid_at_ack", 32'(nib_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_after_ack", 32'(nib_valid), 32'd1);
        wait_idle(200, "t1_idle");
        chk("t1_end_with_busy_fall", 32'(end_flag), 32'd1);
        @(negedge clk);
        chk("t1_end_pulse_off", 32'(end_flag), 32'd0);
        chk("t1_nreq", 32'(req_q.size()), 32'd2);
        chk("t1_addr0", 32'(req_q[0]), 32'h40);
        chk("t1_addr1", 32'(req_q[1]), 32'h44);
        chk("t1_end_cnt", 32'(end_cnt), 32'd1);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty range.
        end_cnt = 0; req_q.delete();
        pulse(24'd5, 24'd4, 1, 0);
        @(negedge clk);
        chk("e_end_flag", 32'(end_flag), 32'd1);
        chk("e_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("e_end_off", 32'(end_flag), 32'd0);
        repeat (5) @(posedge clk);
        chk("e_no_req", 32'(req_q.size()), 32'd0);

        // Top of the word-address space, no wrap.
        ack_lat = 1; end_cnt = 0; req_q.delete();
        pulse(24'hFFFFFE, 24'hFFFFFF, 1, 0);
        wait_idle(200, "w_idle");
        @(negedge clk);
        chk("w_nreq", 32'(req_q.size()), 32'd2);
        chk("w_addr0", 32'(req_q[0]), 32'h3FFFFF8);
        chk("w_addr1", 32'(req_q[1]), 32'h3FFFFFC);
        chk("w_end_cnt", 32'(end_cnt), 32'd1);
        chk("w_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stop with a request outstanding.
        ack_lat = 10; rd_en = 0; end_cnt = 0; req_q.delete();
        pulse(24'h200, 24'h203, 1, 0);
        repeat (3) @(posedge clk);
        pulse(24'h0, 24'h0, 0, 1);
        rd_en = 1;
        @(negedge clk);
        chk("s_valid", 32'(nib_valid), 32'd0);
        chk("s_busy", 32'(busy), 32'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("s_valid_late", 32'(nib_valid), 32'd0);
        chk("s_nreq", 32'(req_q.size()), 32'd1);
        chk("s_end_cnt", 32'(end_cnt), 32'd0);

        // Restart while the first request is in flight.
        ack_lat = 6; rd_en = 1; end_cnt = 0; req_q.delete();
        pulse(24'h300, 24'h305, 1, 0);
        @(posedge clk);
        pulse(24'h100, 24'h100, 1, 0);
        wait_idle(200, "r_idle");
        @(negedge clk);
        chk("r_nreq", 32'(req_q.size()), 32'd2);
        chk("r_addr1", 32'(req_q[1]), 32'h400);
        chk("r_end_cnt", 32'(end_cnt), 32'd1);
        chk("r_sb_empty", 32'(exp_q.size()), 32'd0);

        // Start and stop together: stop wins.
        ack_lat = 2; rd_en = 0; end_cnt = 0; req_q.delete();
        pulse(24'h20, 24'h21, 1, 0);
        repeat (4) @(posedge clk);
        pulse(24'h30, 24'h30, 1, 1);
        @(negedge clk);
        chk("sw_busy", 32'(busy), 32'd0);
        chk("sw_valid", 32'(nib_valid), 32'd0);
        rd_en = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        found = 0;
        foreach (req_q[i]) if (req_q[i] == 26'hC0) found = 1;
        chk("sw_no_new_req", 32'(found), 32'd0);
        chk("sw_end_cnt", 32'(end_cnt), 32'd0);

        // Continuous reads, short ack latency.
        ack_lat = 2; rd_en = 1; end_cnt = 0; gaps = 0; saw_valid = 0; gap_mode = 1;
        pulse(24'h40, 24'h43, 1, 0);
        wait_idle(300, "g_idle");
        @(negedge clk);
        gap_mode = 0;
        chk("g_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("g_end_cnt", 32'(end_cnt), 32'd1);
`ifdef ADPCM_FETCH_PREFETCH_EN
        chk("g_no_gaps", 32'(gaps), 32'd0);
`else
        chk("g_gaps_present", 32'(gaps > 0), 32'd1);
`endif

        // Reset in the middle of a run.
        ack_lat = 3; rd_rand = 1;
        pulse(24'h50, 24'h5F, 1, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("m_busy_pre", 32'(busy), 32'd1);
        @(posedge clk); #1;
        nRESET = 1'b0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset_outputs("m");
        @(posedge clk); #1;
        nRESET = 1'b1;
        rd_rand = 0;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
